urna_arbiter: RTL and testbench
===============================

Name: urna_arbiter

Overview:
- Shared tally controller for a multi-booth election.
- Up to N_BOOTHS voting booths each present one completed vote (C1, C2 or null) through a req/ack handshake.
- The block grants booths round-robin, updates one shared set of tally counters per cycle, and sequences the election through open → drain → closed.
- It sits between the per-booth vote-entry FSMs and the result display/readout logic.

Parameters:
- N_BOOTHS, 4, number of requesting booths (2..8).
- CNT_W, 8, width of each tally counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- open  in  1  one-cycle pulse: clear tallies, start election.
- finish  in  1  one-cycle pulse: close election (drain pending votes first).
- vote_req  in  N_BOOTHS  per-booth vote request.
- vote_code  in  2*N_BOOTHS  per-booth code; booth i uses bits [2i+1:2i].
- vote_ack  out  N_BOOTHS  per-booth one-cycle acknowledge.
- state  out  2  current phase: 00 IDLE, 01 OPEN, 10 DRAIN, 11 CLOSED.
- total_c1  out  CNT_W  C1 tally.
- total_c2  out  CNT_W  C2 tally.
- total_null  out  CNT_W  null tally.
- results_valid  out  1  high only in CLOSED.
- overflow  out  1  sticky; set when any tally would exceed its maximum.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all tallies 0; vote_ack=0; results_valid=0; overflow=0.
  - Round-robin pointer = booth 0; drain mask = 0.
- Vote codes:
  - 01 → C1; 10 → C2.
  - 00 and 11 → null.
- Handshake:
  - Booth raises req with code stable and holds both until it sees ack.
  - ack is registered: req visible at edge t → ack high during cycle t+1, and the tally is updated at that same edge.
  - A booth whose ack is currently high is masked from arbitration that cycle, so a req still high gives no double count.
  - Booth may raise a new req the cycle after ack.
- Arbitration:
  - Among eligible requesters, grant the first at or after the pointer (ascending, wrapping).
  - After a grant to booth i, pointer ← (i+1) mod N_BOOTHS.
  - At most one grant per cycle; throughput is one vote per cycle.
- FSM:
  - IDLE: no grants. open → OPEN; tallies and overflow cleared on the same edge.
  - OPEN: arbitrate all requesters. finish → DRAIN; the drain mask is loaded with vote_req at that edge, minus any booth acked in that cycle.
  - DRAIN: only booths in the drain mask are eligible. Each grant clears its mask bit. New requests outside the mask are never acked. Mask empty → CLOSED on the next edge.
  - DRAIN with an empty mask on entry → CLOSED after exactly one cycle.
  - CLOSED: no grants; tallies frozen; results_valid=1. open → OPEN with tallies cleared.
- Simultaneous events:
  - open and finish together: open wins in IDLE/CLOSED; finish wins in OPEN.
  - open in DRAIN is ignored.
  - finish in IDLE or CLOSED is ignored.
- Arithmetic: counters saturate at 2^CNT_W−1. The ack is still issued, the count is not incremented, and overflow is set (sticky until open or reset).
- Reset mid-operation: all state is lost immediately and pending reqs are not acked; booths re-request after reset.

Optional Feature:
- URNA_SWAP_EN defined:
  - Adds input port swap (1 bit, quasi-static).
  - When swap=1, codes 01 and 10 are exchanged before tallying (01→C2, 10→C1); null codes are unaffected.
  - swap is sampled on the same edge as the tally update.
- URNA_SWAP_EN undefined: no swap port; mapping is fixed as listed above.

Decomposition:
- Package urna_pkg holds:
  - vote code constants VOTE_NULL=2'b00, VOTE_C1=2'b01, VOTE_C2=2'b10;
  - state encoding ST_IDLE/ST_OPEN/ST_DRAIN/ST_CLOSED;
  - saturating-increment function.
- Sub-module urna_rr_arbiter:
  - inputs: eligible mask and pointer;
  - outputs: one-hot grant and next pointer;
  - combinational picker plus pointer register.

Test Plan:
- Reset, open, booth 2 req with code 01 → ack[2] one cycle later, total_c1=1, others 0, state=01.
- All 4 booths req continuously with code 10 → acks rotate 0,1,2,3,0, one per cycle; total_c2=8 after 8 acks with no gaps.
- Booths 1 and 3 pending, finish pulse, then booth 0 raises req → booths 1 and 3 acked, booth 0 never acked; state 10 → 11; results_valid=1.
- CNT_W=8, preload 255 C1 votes, one more C1 → ack issued, total_c1 stays 255, overflow=1. A following open clears tallies and overflow.
- rst_n low during DRAIN with 2 pending → outputs reset immediately, no acks, state=00.
- URNA_SWAP_EN, swap=1, codes 01, 10, 11 → total_c2=1, total_c1=1, total_null=1.

Source files
------------

// File: rtl/urna_pkg.sv
// Shared definitions for the election tally controller: vote codes, phase encoding
// and the saturating counter increment used by every tally.
package urna_pkg;

    localparam logic [1:0] VOTE_NULL = 2'b00;
    localparam logic [1:0] VOTE_C1   = 2'b01;
    localparam logic [1:0] VOTE_C2   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OPEN   = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_CLOSED = 2'b11
    } urna_state_t;

    // Increment that sticks at 2^width-1 instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/urna_arbiter_if.sv
// Booth-side vote handshake bundle: per-booth request, 2-bit code and registered ack.
// Booths drive through master, the tally controller receives through slave.
interface urna_arbiter_if #(
    parameter int N_BOOTHS = 4
);
    logic [N_BOOTHS-1:0]   vote_req;
    logic [2*N_BOOTHS-1:0] vote_code;
    logic [N_BOOTHS-1:0]   vote_ack;

    modport master (output vote_req, output vote_code, input vote_ack);
    modport slave  (input vote_req, input vote_code, output vote_ack);
endinterface

// File: rtl/urna_rr_arbiter.sv
// Round-robin picker: grants the first eligible booth at or after the pointer, wrapping.
// Combinational grant, pointer advances past the winner on the following edge.
module urna_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] eligible,
    output logic [N-1:0] grant
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                next_ptr   = PTR_W'((int'(idx) + 1) % N);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/urna_arbiter.sv
// Election tally controller: round-robin vote intake, one tally update per cycle, IDLE/OPEN/DRAIN/CLOSED.
// Optional URNA_SWAP_EN adds a swap input that exchanges the C1/C2 codes before tallying.
module urna_arbiter
    import urna_pkg::*;
#(
    parameter int N_BOOTHS = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             open,
    input  logic             finish,
`ifdef URNA_SWAP_EN
    input  logic             swap,
`endif
    urna_arbiter_if.slave    booth,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] total_c1,
    output logic [CNT_W-1:0] total_c2,
    output logic [CNT_W-1:0] total_null,
    output logic             results_valid,
    output logic             overflow
);
    urna_state_t         st_q, st_d;
    logic [N_BOOTHS-1:0] ack_q, drain_q, drain_d, eligible, grant;
    logic [1:0]          sel_code;
    logic                raw_c1, raw_c2, to_c1, to_c2, clear;

    urna_rr_arbiter #(.N(N_BOOTHS)) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .grant    (grant)
    );

    // A booth whose ack is high this cycle is still holding req; masking it avoids a double count.
    always_comb begin
        eligible = '0;
        case (st_q)
            ST_OPEN:  eligible = booth.vote_req & ~ack_q;
            ST_DRAIN: eligible = booth.vote_req & drain_q & ~ack_q;
            default:  eligible = '0;
        endcase
    end

    always_comb begin
        st_d    = st_q;
        drain_d = drain_q;
        case (st_q)
            ST_IDLE:   if (open) st_d = ST_OPEN;
            ST_OPEN: begin
                if (finish) begin
                    st_d    = ST_DRAIN;
                    drain_d = booth.vote_req & ~ack_q & ~grant;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q & ~grant;
                if (drain_q == '0) st_d = ST_CLOSED;
            end
            ST_CLOSED: if (open) st_d = ST_OPEN;
            default:   st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_code = VOTE_NULL;
        for (int i = 0; i < N_BOOTHS; i++) begin
            if (grant[i]) sel_code = booth.vote_code[2*i +: 2];
        end
    end

    assign raw_c1 = (sel_code == VOTE_C1);
    assign raw_c2 = (sel_code == VOTE_C2);
`ifdef URNA_SWAP_EN
    assign to_c1 = swap ? raw_c2 : raw_c1;
    assign to_c2 = swap ? raw_c1 : raw_c2;
`else
    assign to_c1 = raw_c1;
    assign to_c2 = raw_c2;
`endif

    assign clear = open && ((st_q == ST_IDLE) || (st_q == ST_CLOSED));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= '0;
            drain_q    <= '0;
            total_c1   <= '0;
            total_c2   <= '0;
            total_null <= '0;
            overflow   <= 1'b0;
        end else begin
            ack_q   <= grant;
            drain_q <= drain_d;
            if (clear) begin
                total_c1   <= '0;
                total_c2   <= '0;
                total_null <= '0;
                overflow   <= 1'b0;
            end else if (|grant) begin
                if (to_c1) begin
                    if (&total_c1) overflow <= 1'b1;
                    total_c1 <= CNT_W'(sat_inc(32'(total_c1), CNT_W));
                end else if (to_c2) begin
                    if (&total_c2) overflow <= 1'b1;
                    total_c2 <= CNT_W'(sat_inc(32'(total_c2), CNT_W));
                end else begin
                    if (&total_null) overflow <= 1'b1;
                    total_null <= CNT_W'(sat_inc(32'(total_null), CNT_W));
                end
            end
        end
    end

    assign booth.vote_ack = ack_q;
    assign state          = st_q;
    assign results_valid  = (st_q == ST_CLOSED);

endmodule

// File: tb/tb_urna_arbiter.sv
// Directed bench for urna_arbiter: cycle table for the main flow plus sequences for saturation,
// mid-drain reset and the C1/C2 mapping (swapped when URNA_SWAP_EN is defined).
module tb_urna_arbiter;

    typedef struct packed {
        logic       o;
        logic       f;
        logic [3:0] req;
        logic [7:0] code;
        logic [3:0] ack;
        logic [1:0] st;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] nl;
        logic       rv;
        logic       ov;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       open_s;
    logic       finish_s;
    logic [1:0] state;
    logic [7:0] c1, c2, nl;
    logic       rv, ov;
`ifdef URNA_SWAP_EN
    logic       swap_s;
`endif

    int checks = 0;
    int errors = 0;

    vec_t tbl[22];

    urna_arbiter_if #(.N_BOOTHS(4)) bif ();

    urna_arbiter #(.N_BOOTHS(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .open          (open_s),
        .finish        (finish_s),
`ifdef URNA_SWAP_EN
        .swap          (swap_s),
`endif
        .booth         (bif),
        .state         (state),
        .total_c1      (c1),
        .total_c2      (c2),
        .total_null    (nl),
        .results_valid (rv),
        .overflow      (ov)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic o, input logic f, input logic [3:0] req,
                                input logic [7:0] code, input logic [3:0] ack, input logic [1:0] st,
                                input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] en,
                                input logic erv, input logic eov);
        vec_t v;
        v.o = o; v.f = f; v.req = req; v.code = code; v.ack = ack; v.st = st;
        v.c1 = e1; v.c2 = e2; v.nl = en; v.rv = erv; v.ov = eov;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ack, input logic [1:0] st,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] en,
                           input logic erv, input logic eov);
        chk({tag, "_ack"}, 32'(bif.vote_ack), 32'(ack));
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_c1"}, 32'(c1), 32'(e1));
        chk({tag, "_c2"}, 32'(c2), 32'(e2));
        chk({tag, "_null"}, 32'(nl), 32'(en));
        chk({tag, "_rv"}, 32'(rv), 32'(erv));
        chk({tag, "_ovf"}, 32'(ov), 32'(eov));
    endtask

    task automatic drive(input logic o, input logic f, input logic [3:0] req, input logic [7:0] code);
        open_s        = o;
        finish_s      = f;
        bif.vote_req  = req;
        bif.vote_code = code;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              o  f  req   code   ack   st  c1 c2 nl rv ov
        tbl[0]  = mk(1, 0, 4'h0, 8'h00, 4'h0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 4'h4, 8'h10, 4'h4, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 4'h8, 8'hC0, 4'h8, 1, 1, 0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 4'h0, 8'h00, 4'h0, 1, 1, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 4'hF, 8'hAA, 4'h1, 1, 1, 1, 1, 0, 0);
        tbl[5]  = mk(0, 0, 4'hF, 8'hAA, 4'h2, 1, 1, 2, 1, 0, 0);
        tbl[6]  = mk(0, 0, 4'hF, 8'hAA, 4'h4, 1, 1, 3, 1, 0, 0);
        tbl[7]  = mk(0, 0, 4'hF, 8'hAA, 4'h8, 1, 1, 4, 1, 0, 0);
        tbl[8]  = mk(0, 0, 4'hF, 8'hAA, 4'h1, 1, 1, 5, 1, 0, 0);
        tbl[9]  = mk(0, 0, 4'hF, 8'hAA, 4'h2, 1, 1, 6, 1, 0, 0);
        tbl[10] = mk(0, 0, 4'hF, 8'hAA, 4'h4, 1, 1, 7, 1, 0, 0);
        tbl[11] = mk(0, 0, 4'hF, 8'hAA, 4'h8, 1, 1, 8, 1, 0, 0);
        tbl[12] = mk(0, 0, 4'h0, 8'h00, 4'h0, 1, 1, 8, 1, 0, 0);
        // finish with booths 1 and 3 pending; booth 1 wins the finish edge, booth 3 drains
        tbl[13] = mk(0, 1, 4'hA, 8'h84, 4'h2, 2, 2, 8, 1, 0, 0);
        tbl[14] = mk(0, 0, 4'h9, 8'h81, 4'h8, 2, 2, 9, 1, 0, 0);
        tbl[15] = mk(0, 0, 4'h1, 8'h01, 4'h0, 3, 2, 9, 1, 1, 0);
        tbl[16] = mk(0, 0, 4'h1, 8'h01, 4'h0, 3, 2, 9, 1, 1, 0);
        tbl[17] = mk(0, 1, 4'h0, 8'h00, 4'h0, 3, 2, 9, 1, 1, 0);
        tbl[18] = mk(1, 1, 4'h0, 8'h00, 4'h0, 1, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 4'h0, 8'h00, 4'h0, 2, 0, 0, 0, 0, 0);
        tbl[20] = mk(1, 0, 4'h0, 8'h00, 4'h0, 3, 0, 0, 0, 1, 0);
        tbl[21] = mk(1, 0, 4'h0, 8'h00, 4'h0, 1, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        drive(0, 0, 4'h0, 8'h00);
`ifdef URNA_SWAP_EN
        swap_s = 1'b0;
`endif
        #12;
        chk_all("reset", 4'h0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 22; k++) begin
            drive(tbl[k].o, tbl[k].f, tbl[k].req, tbl[k].code);
            tick();
            chk_all($sformatf("row%0d", k), tbl[k].ack, tbl[k].st, tbl[k].c1, tbl[k].c2,
                    tbl[k].nl, tbl[k].rv, tbl[k].ov);
        end

        // Saturation: booths 0 and 1 alternate C1 votes, one per cycle.
        drive(0, 0, 4'h3, 8'h05);
        for (int i = 0; i < 255; i++) tick();
        chk("sat_pre_c1", 32'(c1), 32'd255);
        chk("sat_pre_ovf", 32'(ov), 32'd0);
        tick();
        chk_all("sat_hit", 4'h2, 2'd1, 8'd255, 8'd0, 8'd0, 1'b0, 1'b1);
        drive(0, 1, 4'h0, 8'h00);
        tick();
        chk_all("sat_drain", 4'h0, 2'd2, 8'd255, 8'd0, 8'd0, 1'b0, 1'b1);
        drive(0, 0, 4'h0, 8'h00);
        tick();
        chk_all("sat_closed", 4'h0, 2'd3, 8'd255, 8'd0, 8'd0, 1'b1, 1'b1);
        drive(1, 0, 4'h0, 8'h00);
        tick();
        chk_all("sat_reopen", 4'h0, 2'd1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);

        // Reset in DRAIN with booths 0 and 1 still pending.
        drive(0, 1, 4'h7, 8'h00);
        tick();
        chk_all("rst_pre", 4'h4, 2'd2, 8'd0, 8'd0, 8'd1, 1'b0, 1'b0);
        drive(0, 0, 4'h3, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rst_async", 4'h0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        chk("rst_hold_ack", 32'(bif.vote_ack), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_idle_ack", 32'(bif.vote_ack), 32'd0);
        chk("rst_idle_state", 32'(state), 32'd0);

        // C1/C2 mapping: booth0 code 01, booth1 code 10, booth2 code 11.
        drive(1, 0, 4'h0, 8'h00);
        tick();
        chk("map_open_state", 32'(state), 32'd1);
`ifdef URNA_SWAP_EN
        swap_s = 1'b1;
`endif
        drive(0, 0, 4'h7, 8'h39);
        tick();
`ifdef URNA_SWAP_EN
        chk_all("map_v1", 4'h1, 2'd1, 8'd0, 8'd1, 8'd0, 1'b0, 1'b0);
`else
        chk_all("map_v1", 4'h1, 2'd1, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0);
`endif
        drive(0, 0, 4'h6, 8'h39);
        tick();
        chk_all("map_v2", 4'h2, 2'd1, 8'd1, 8'd1, 8'd0, 1'b0, 1'b0);
        drive(0, 0, 4'h4, 8'h39);
        tick();
        chk_all("map_v3", 4'h4, 2'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0);
        drive(0, 0, 4'h0, 8'h00);
        tick();
        chk("map_quiet_ack", 32'(bif.vote_ack), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
